// File: rtl/mcs_fp_bridge_ws.sv
`default_nettype none
// ============================================================================
// Module      : mcs_fp_bridge_ws
// Description : Registered, wait-state-capable bridge from the MicroBlaze MCS
//               I/O bus to the FPro bus. Decodes an 8-bit base region into
//               NUM_SLOTS one-hot chip-selects, holds each transaction until
//               the addressed slave acknowledges (or a timeout fires), then
//               completes the MCS cycle with a one-cycle io_ready pulse.
//               Default map: slot 0 = MMIO, slot 1 = video.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   io_addr_strobe        : MCS address strobe
//   io_read_strobe        : MCS read strobe
//   io_write_strobe       : MCS write strobe (wins if both strobes are high)
//   io_addr[31:0]         : MCS byte address
//   io_byte_enable[3:0]   : MCS byte lanes
//   io_write_data[31:0]   : MCS write data
//   io_read_data[31:0]    : read data returned to MCS (held between cycles)
//   io_ready              : one-cycle transaction-complete pulse
//   fp_addr[ADDR_W-1:0]   : FPro word address
//   fp_cs[NUM_SLOTS-1:0]  : one-hot slot select, held for the whole request
//   fp_read, fp_write     : one-cycle FPro request pulses
//   fp_byte_en[3:0]       : FPro byte lanes
//   fp_write_data[31:0]   : FPro write data
//   fp_read_data[31:0]    : FPro read data, valid while fp_ack is high
//   fp_ack                : FPro slave acknowledge
//   err_clr               : clears err_flag
//   err_flag              : sticky timeout indication
// ============================================================================
module mcs_fp_bridge_ws #(
  parameter logic [31:0] BRIDGE_BASE = 32'hc000_0000,
  parameter int          ADDR_W      = 21,
  parameter int          NUM_SLOTS   = 2,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_DATA    = 32'hdead_beef
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // MCS I/O bus
  input  logic                 io_addr_strobe,
  input  logic                 io_read_strobe,
  input  logic                 io_write_strobe,
  input  logic [31:0]          io_addr,
  input  logic [3:0]           io_byte_enable,
  input  logic [31:0]          io_write_data,
  output logic [31:0]          io_read_data,
  output logic                 io_ready,
  // FPro bus
  output logic [ADDR_W-1:0]    fp_addr,
  output logic [NUM_SLOTS-1:0] fp_cs,
  output logic                 fp_read,
  output logic                 fp_write,
  output logic [3:0]           fp_byte_en,
  output logic [31:0]          fp_write_data,
  input  logic [31:0]          fp_read_data,
  input  logic                 fp_ack,
  // Error reporting
  input  logic                 err_clr,
  output logic                 err_flag
);

  localparam int                   SLOT_W    = $clog2(NUM_SLOTS);
  localparam logic [15:0]          C_TIMEOUT = 16'(TIMEOUT);
  localparam logic [NUM_SLOTS-1:0] C_CS_ONE  = NUM_SLOTS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_cnt;
  logic        r_dir;    // 1 = write

  logic                 w_hit;
  logic                 w_start;
  logic [SLOT_W-1:0]    w_slot;
  logic [ADDR_W-1:0]    w_fp_addr;
  logic [NUM_SLOTS-1:0] w_cs_dec;
  logic [15:0]          w_cnt_next;
  logic                 w_timeout;
  logic                 w_unused;

  // Address decode: byte address -> word address, split into slot / offset.
  assign w_hit     = (io_addr[31:24] == BRIDGE_BASE[31:24]);
  assign w_start   = io_addr_strobe & w_hit & (io_read_strobe | io_write_strobe);
  assign w_fp_addr = io_addr[ADDR_W+1:2];
  assign w_slot    = io_addr[ADDR_W+SLOT_W+1:ADDR_W+2];
  assign w_cs_dec  = C_CS_ONE << w_slot;

  // r_cnt never exceeds TIMEOUT-1, so the increment cannot wrap.
  assign w_cnt_next = r_cnt + 16'd1;
  assign w_timeout  = (w_cnt_next == C_TIMEOUT);

  // Byte-offset bits and any address bits between the slot field and the
  // region field carry no meaning for this bridge.
  assign w_unused = ^io_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 16'd0;
      r_dir         <= 1'b0;
      io_read_data  <= 32'd0;
      io_ready      <= 1'b0;
      fp_addr       <= '0;
      fp_cs         <= '0;
      fp_read       <= 1'b0;
      fp_write      <= 1'b0;
      fp_byte_en    <= 4'd0;
      fp_write_data <= 32'd0;
      err_flag      <= 1'b0;
    end else begin
      // Pulse outputs default low; the FSM raises them for one cycle.
      io_ready <= 1'b0;
      fp_read  <= 1'b0;
      fp_write <= 1'b0;

      // Clear first so that a timeout in the same cycle overrides it.
      if (err_clr) begin
        err_flag <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dir         <= io_write_strobe;
            fp_addr       <= w_fp_addr;
            fp_cs         <= w_cs_dec;
            fp_read       <= ~io_write_strobe;
            fp_write      <= io_write_strobe;
            fp_byte_en    <= io_byte_enable;
            fp_write_data <= io_write_data;
            r_state       <= S_REQ;
          end
        end

        S_REQ: begin
          r_cnt <= 16'd0;
          if (fp_ack) begin
            fp_cs    <= '0;
            io_ready <= 1'b1;
            if (!r_dir) begin
              io_read_data <= fp_read_data;
            end
            r_state <= S_DONE;
          end else begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (fp_ack) begin
            fp_cs    <= '0;
            io_ready <= 1'b1;
            if (!r_dir) begin
              io_read_data <= fp_read_data;
            end
            r_state <= S_DONE;
          end else if (w_timeout) begin
            // Slave never answered: complete the MCS cycle with an error.
            fp_cs    <= '0;
            io_ready <= 1'b1;
            err_flag <= 1'b1;
            if (!r_dir) begin
              io_read_data <= ERR_DATA;
            end
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mcs_fp_bridge_ws.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcs_fp_bridge_ws
// Description : Scoreboard bench for mcs_fp_bridge_ws. Stimulus pushes the
//               hand-computed FPro request and MCS completion into queues;
//               a monitor pops and compares them when the DUT presents
//               fp_read/fp_write or io_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcs_fp_bridge_ws;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        reset_n;
  logic        io_addr_strobe;
  logic        io_read_strobe;
  logic        io_write_strobe;
  logic [31:0] io_addr;
  logic [3:0]  io_byte_enable;
  logic [31:0] io_write_data;
  logic [31:0] io_read_data;
  logic        io_ready;
  logic [20:0] fp_addr;
  logic [1:0]  fp_cs;
  logic        fp_read;
  logic        fp_write;
  logic [3:0]  fp_byte_en;
  logic [31:0] fp_write_data;
  logic [31:0] fp_read_data;
  logic        fp_ack;
  logic        err_clr;
  logic        err_flag;

  mcs_fp_bridge_ws #(
    .BRIDGE_BASE (32'hc000_0000),
    .ADDR_W      (21),
    .NUM_SLOTS   (2),
    .TIMEOUT     (TB_TIMEOUT),
    .ERR_DATA    (32'hdead_beef)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .io_addr_strobe  (io_addr_strobe),
    .io_read_strobe  (io_read_strobe),
    .io_write_strobe (io_write_strobe),
    .io_addr         (io_addr),
    .io_byte_enable  (io_byte_enable),
    .io_write_data   (io_write_data),
    .io_read_data    (io_read_data),
    .io_ready        (io_ready),
    .fp_addr         (fp_addr),
    .fp_cs           (fp_cs),
    .fp_read         (fp_read),
    .fp_write        (fp_write),
    .fp_byte_en      (fp_byte_en),
    .fp_write_data   (fp_write_data),
    .fp_read_data    (fp_read_data),
    .fp_ack          (fp_ack),
    .err_clr         (err_clr),
    .err_flag        (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] rd;
    logic        err;
  } io_exp_t;

  typedef struct {
    logic [1:0]  cs;
    logic [20:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
  } fp_exp_t;

  io_exp_t io_q[$];
  fp_exp_t fp_q[$];
  fp_exp_t cur_req;
  io_exp_t cur_io;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (io_ready) begin
        if (io_q.size() == 0) begin
          chk("unexpected_io_ready", 64'd1, 64'd0);
        end else begin
          cur_io = io_q.pop_front();
          chk("ready_cycle", 64'(cyc), 64'(cur_io.cyc));
          chk("io_read_data", 64'(io_read_data), 64'(cur_io.rd));
          chk("err_flag_at_done", 64'(err_flag), 64'(cur_io.err));
        end
      end
      if (fp_read || fp_write) begin
        if (fp_q.size() == 0) begin
          chk("unexpected_fp_req", 64'd1, 64'd0);
        end else begin
          cur_req = fp_q.pop_front();
          chk("req_cs", 64'(fp_cs), 64'(cur_req.cs));
          chk("req_addr", 64'(fp_addr), 64'(cur_req.addr));
          chk("req_read", 64'(fp_read), 64'(cur_req.rd));
          chk("req_write", 64'(fp_write), 64'(cur_req.wr));
          chk("req_wdata", 64'(fp_write_data), 64'(cur_req.wd));
          chk("req_be", 64'(fp_byte_en), 64'(cur_req.be));
        end
      end else if (fp_cs != 2'b00) begin
        chk("hold_cs", 64'(fp_cs), 64'(cur_req.cs));
        chk("hold_addr", 64'(fp_addr), 64'(cur_req.addr));
        chk("hold_wdata", 64'(fp_write_data), 64'(cur_req.wd));
        chk("hold_be", 64'(fp_byte_en), 64'(cur_req.be));
      end
    end
  end

  // One MCS transaction. waits < 0 means the slave never acknowledges.
  // All expected values are supplied by the caller.
  task automatic txn(input logic [31:0] addr, input bit rd, input bit wr,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int waits, input logic [31:0] ack_data,
                     input bit hit, input logic [1:0] ecs, input logic [20:0] efa,
                     input int lat, input logic [31:0] erd, input bit eerr,
                     input bit push_io, input int run);
    int c;
    @(posedge clk); #1;
    c = cyc;
    io_addr         = addr;
    io_addr_strobe  = 1'b1;
    io_read_strobe  = rd;
    io_write_strobe = wr;
    io_write_data   = wd;
    io_byte_enable  = be;
    if (hit) fp_q.push_back('{cs: ecs, addr: efa, rd: !wr, wr: wr, wd: wd, be: be});
    if (hit && push_io) io_q.push_back('{cyc: c + lat, rd: erd, err: eerr});
    for (int i = 1; i <= run; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_addr         = 32'hc0ff_fffc;
        io_write_data   = ~wd;
        io_byte_enable  = ~be;
      end
      fp_ack       = (waits >= 0) && (i == 1 + waits);
      fp_read_data = fp_ack ? ack_data : 32'h0bad_0bad;
    end
    fp_ack = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_io_ready"}, 64'(io_ready), 64'd0);
    chk({tag, "_fp_cs"}, 64'(fp_cs), 64'd0);
    chk({tag, "_fp_read"}, 64'(fp_read), 64'd0);
    chk({tag, "_fp_write"}, 64'(fp_write), 64'd0);
    chk({tag, "_err_flag"}, 64'(err_flag), 64'd0);
    chk({tag, "_io_read_data"}, 64'(io_read_data), 64'd0);
    chk({tag, "_fp_addr"}, 64'(fp_addr), 64'd0);
    chk({tag, "_fp_write_data"}, 64'(fp_write_data), 64'd0);
    chk({tag, "_fp_byte_en"}, 64'(fp_byte_en), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset_n         = 1'b0;
    io_addr_strobe  = 1'b0;
    io_read_strobe  = 1'b0;
    io_write_strobe = 1'b0;
    io_addr         = 32'd0;
    io_byte_enable  = 4'd0;
    io_write_data   = 32'd0;
    fp_read_data    = 32'd0;
    fp_ack          = 1'b0;
    err_clr         = 1'b0;

    #3;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Zero-wait read, slot 0.
    txn(32'hc000_0010, 1, 0, 32'h0000_0000, 4'hf, 0, 32'h1234_5678,
        1, 2'b01, 21'd4, 2, 32'h1234_5678, 0, 1, 4);

    // Write to slot 1 with 3 wait cycles; read data must stay unchanged.
    txn(32'hc080_0008, 0, 1, 32'ha5a5_0001, 4'b0011, 3, 32'h7777_7777,
        1, 2'b10, 21'd2, 5, 32'h1234_5678, 0, 1, 7);

    // Timed-out read.
    txn(32'hc000_0100, 1, 0, 32'h0000_0000, 4'hf, -1, 32'h0,
        1, 2'b01, 21'h40, 2 + TB_TIMEOUT, 32'hdead_beef, 1, 1, TB_TIMEOUT + 4);
    chk("err_flag_sticky", 64'(err_flag), 64'd1);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chk("err_flag_cleared", 64'(err_flag), 64'd0);

    // Miss: outside the bridge region, must be ignored.
    txn(32'h8000_0000, 1, 0, 32'h0, 4'hf, 0, 32'h9999_9999,
        0, 2'b00, 21'd0, 2, 32'h0, 0, 0, 4);
    chk("miss_fp_cs", 64'(fp_cs), 64'd0);

    // Both strobes: treated as a write.
    txn(32'hc000_0030, 1, 1, 32'h0102_0304, 4'b1100, 1, 32'h0,
        1, 2'b01, 21'hc, 3, 32'hdead_beef, 0, 1, 5);

    // Busy: a second strobe issued during WAIT must be ignored.
    @(posedge clk); #1;
    c = cyc;
    io_addr = 32'hc000_0020; io_addr_strobe = 1'b1; io_read_strobe = 1'b1;
    io_write_strobe = 1'b0; io_write_data = 32'h1111_2222; io_byte_enable = 4'hf;
    fp_q.push_back('{cs: 2'b01, addr: 21'd8, rd: 1'b1, wr: 1'b0, wd: 32'h1111_2222, be: 4'hf});
    io_q.push_back('{cyc: c + 4, rd: 32'h0000_cafe, err: 1'b0});
    @(posedge clk); #1;                     // REQ
    io_addr_strobe = 1'b0; io_read_strobe = 1'b0;
    @(posedge clk); #1;                     // WAIT 1: stray hit strobe
    io_addr = 32'hc080_0004; io_addr_strobe = 1'b1; io_write_strobe = 1'b1;
    io_write_data = 32'h3333_4444; io_byte_enable = 4'h1;
    @(posedge clk); #1;                     // WAIT 2: acknowledge
    io_addr_strobe = 1'b0; io_write_strobe = 1'b0;
    fp_ack = 1'b1; fp_read_data = 32'h0000_cafe;
    @(posedge clk); #1;
    fp_ack = 1'b0; fp_read_data = 32'h0;
    repeat (4) @(posedge clk);

    // Timed-out write: err_flag set, read data unchanged.
    txn(32'hc080_000c, 0, 1, 32'hfeed_f00d, 4'hf, -1, 32'h0,
        1, 2'b10, 21'd3, 2 + TB_TIMEOUT, 32'h0000_cafe, 1, 1, TB_TIMEOUT + 4);
    chk("err_flag_after_wr_timeout", 64'(err_flag), 64'd1);

    // Reset in the middle of WAIT.
    txn(32'hc000_0040, 1, 0, 32'h0, 4'hf, -1, 32'h0,
        1, 2'b01, 21'h10, 0, 32'h0, 0, 0, 2);
    chk("mid_wait_cs_before_reset", 64'(fp_cs), 64'd1);
    #1 reset_n = 1'b0;
    #1 chk_outputs_zero("async_reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // Bridge accepts the next strobe after reset.
    txn(32'hc000_0004, 1, 0, 32'h0, 4'hf, 0, 32'h5555_aaaa,
        1, 2'b01, 21'd1, 2, 32'h5555_aaaa, 0, 1, 4);

    repeat (3) @(posedge clk);
    #1;
    chk("io_q_drained", 64'(io_q.size()), 64'd0);
    chk("fp_q_drained", 64'(fp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
